ifetch_resp: RTL and testbench
==============================

# ifetch_resp

Instruction-fetch responder: the memory-side end of the fetch interface. Accepts PC fetch requests from the fetch stage with a valid/ready handshake, drives a synchronous instruction RAM (one-cycle read latency), and returns instruction/PC pairs to the decode side through a small credit-controlled buffer. A flush input discards everything buffered or in flight when the PC is redirected by a branch or jump.

## Interface
Parameters:
- ADDR_W, 14, instruction RAM word-address width; RAM address is req_pc[ADDR_W+1:2]
- DEPTH, 4, response buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_pc  in  32  byte address to fetch
- flush  in  1  discard all buffered and in-flight fetches
- mem_en  out  1  RAM read enable
- mem_a  out  ADDR_W  RAM word address
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_inst  out  32  instruction word
- rsp_pc  out  32  PC of rsp_inst
- rsp_err  out  1  misaligned-fetch flag (see Configuration)

## Operation
- State: buffer of DEPTH entries {pc, inst, err}, occupancy count (0..DEPTH), one in-flight stage {valid, pc, err}.
- req_ready = !flush && (count + inflight_valid) < DEPTH; combinational, independent of req_valid and rsp_ready.
- Accept in cycle N: mem_en=1, mem_a=req_pc[ADDR_W+1:2] combinationally in cycle N; in-flight stage loads {1, req_pc, err}.
- Cycle N+1: mem_rdata plus in-flight pc/err written into buffer tail at end of cycle; in-flight valid clears unless a new request is accepted.
- rsp_valid = (count != 0); rsp_inst/rsp_pc/rsp_err show the head entry; pop on handshake.
- Push and pop in the same cycle: count unchanged; legal at any occupancy, including full.
- Credit rule guarantees no overflow; a push when full cannot occur.
- Outputs stay stable while rsp_valid && !rsp_ready.
- flush: count→0, head/tail pointers→0, in-flight valid→0 at end of cycle; RAM data returning during the flush cycle is dropped; req_ready=0 that cycle; a simultaneous rsp handshake is allowed and has no further effect.
- mem_en=0 whenever no request is accepted; mem_a then holds the value of req_pc[ADDR_W+1:2] (don't-care).

## Timing
- Reset (rst=0 at an edge): count=0, pointers=0, in-flight valid=0; rsp_valid=0, rsp_inst=0, rsp_pc=0, rsp_err=0, mem_en=0. req_ready=1 during reset, but no requests are accepted while rst=0.
- Reset mid-operation: all buffered/in-flight fetches discarded, same as flush.
- Latency: accept at N → rsp_valid at N+2 when buffer empty.
- Throughput: one fetch per cycle sustained with rsp_ready=1 and DEPTH≥3.
- First cycle after flush: req_ready=1; accept there → rsp_valid two cycles later.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined: request with req_pc[1:0]!=0 is accepted normally but mem_en=0 for it; its entry has err=1, inst=32'h00000013 (NOP), pc=req_pc; ordering with other fetches preserved.
- Not defined: req_pc[1:0] ignored, every accepted request reads RAM, rsp_err tied 0.

## Structure
- Shared package ifetch_pkg: NOP_INST constant (32'h00000013), entry struct {pc[31:0], inst[31:0], err}, default ADDR_W/DEPTH constants.
- One sub-module ifetch_fifo: DEPTH-entry synchronous FIFO with push/pop/clear, count output, head data output; ifetch_resp owns credit logic, in-flight stage and RAM port.

## Test plan
- Reset then single fetch pc=0x0000_0010, RAM word 4 = 0x00500093 → mem_a=4 in accept cycle, rsp_valid two cycles later with inst=0x00500093, pc=0x10.
- Back-to-back pcs 0x0,0x4,0x8,0xC with rsp_ready=1 → req_ready never drops; four responses on consecutive cycles, in order.
- rsp_ready=0, continuous requests → exactly DEPTH (4) accepted, req_ready=0 afterwards; release rsp_ready → 4 responses in order, req_ready reasserts.
- Flush in the cycle after accepting 0x20 with two entries buffered → rsp_valid=0 next cycle, 0x20 never returned; next fetch 0x100 returns normally.
- With IFETCH_MISALIGN_CHK_EN: fetch 0x0000_0006 between 0x0 and 0x4 → mem_en=0 for it; responses 0x0, then {0x6, inst=0x00000013, err=1}, then 0x4. Without the macro: mem_a=1, err=0.
- rst=0 asserted with three entries buffered and one in flight → next cycle rsp_valid=0, all outputs at reset values, no stale response after rst=1.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ifetch_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DEPTH_DEF  = 4;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with push/pop/clear and count.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  entry_t        din,
  output logic [CW-1:0] count,
  output entry_t        head
);
  entry_t        mem [DEPTH];
  logic [PW-1:0] hptr, tptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      hptr  <= '0;
      tptr  <= '0;
      count <= '0;
    end else begin
      if (push) tptr <= tptr + 1'b1;
      if (pop)  hptr <= hptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear && push) mem[tptr] <= din;
  end

  assign head = mem[hptr];
endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: request handshake, 1-cycle RAM port, credit-limited
// response buffer. Define IFETCH_MISALIGN_CHK_EN to flag misaligned PCs as NOP/err.
module ifetch_resp
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  input  logic              flush,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic [31:0]       rsp_pc,
  output logic              rsp_err
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          inf_vld, inf_err;
  logic [31:0]   inf_pc;
  logic [CW-1:0] count;
  logic          accept, mis, push, pop;
  entry_t        din, head;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign mis = (req_pc[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Credits cover both buffered entries and the one still in the RAM stage.
  assign req_ready = !rst || (!flush && ((CW+1)'(count) + (CW+1)'(inf_vld) < (CW+1)'(DEPTH)));
  assign accept    = rst && req_valid && req_ready;
  assign mem_en    = accept && !mis;
  assign mem_a     = req_pc[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst || flush) inf_vld <= 1'b0;
    else               inf_vld <= accept;
    if (accept) begin
      inf_pc  <= req_pc;
      inf_err <= mis;
    end
  end

  assign push = inf_vld && !flush;
  assign pop  = rsp_valid && rsp_ready;
  assign din  = '{pc: inf_pc, inst: (inf_err ? NOP_INST : mem_rdata), err: inf_err};

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .count (count),
    .head  (head)
  );

  // Head fields are masked so an empty buffer always presents zeros.
  assign rsp_valid = (count != '0);
  assign rsp_inst  = rsp_valid ? head.inst : '0;
  assign rsp_pc    = rsp_valid ? head.pc   : '0;
  assign rsp_err   = rsp_valid && head.err;
endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp: queue-based reference model plus literal checks.
module tb_ifetch_resp;
  localparam int ADDR_W = 14;
`ifdef IFETCH_MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  logic clk = 0, rst = 0, req_valid = 0, flush = 0, rsp_ready = 0;
  logic [31:0] req_pc = 0, mem_rdata = 0;
  logic req_ready, mem_en, rsp_valid, rsp_err;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0] rsp_inst, rsp_pc;

  int total = 0, bad = 0;
  logic [31:0] ram [0:(1<<ADDR_W)-1];

  ifetch_resp #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .flush(flush), .mem_en(mem_en), .mem_a(mem_a), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_pc(rsp_pc),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_a];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Reference model: the expected response queue plus the one fetch awaiting RAM data.
  rsp_t q[$];
  bit inf_v = 0, inf_mis = 0, chk_en = 0, zchk = 0;
  logic [31:0] inf_pc = 0;

  always @(negedge clk) begin : model
    bit exp_rdy, acc, mis;
    rsp_t e;
    exp_rdy = !rst ? 1'b1 : (!flush && (q.size() + int'(inf_v)) < 4);
    acc = rst && req_valid && exp_rdy;
    mis = MIS_EN && (req_pc[1:0] != 2'b00);
    if (chk_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
      chk("mem_en", {31'b0, mem_en}, {31'b0, acc && !mis});
      if (acc && !mis) chk("mem_a", {18'b0, mem_a}, {18'b0, req_pc[ADDR_W+1:2]});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("rsp_pc", rsp_pc, q[0].pc);
        chk("rsp_inst", rsp_inst, q[0].inst);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
      end else if (zchk) begin
        chk("rst_pc", rsp_pc, 32'h0);
        chk("rst_inst", rsp_inst, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'h0);
      end
    end
    zchk = !rst;
    if (!rst || flush) begin
      q.delete();
      inf_v = 0;
    end else begin
      if (rsp_ready && q.size() != 0) void'(q.pop_front());
      if (inf_v) begin
        e.pc   = inf_pc;
        e.inst = inf_mis ? 32'h00000013 : ram[inf_pc[ADDR_W+1:2]];
        e.err  = inf_mis;
        q.push_back(e);
      end
      inf_v   = acc;
      inf_pc  = req_pc;
      inf_mis = mis;
    end
    if (!rst) chk_en = 1;
  end

  initial begin
    int nacc;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
    ram[4] = 32'h00500093;

    tick; tick;
    rst = 1;
    tick;

    // Single fetch: latency two cycles
    req_valid = 1; req_pc = 32'h10;
    @(negedge clk);
    chk("t1_mem_a", {18'b0, mem_a}, 32'd4);
    chk("t1_mem_en", {31'b0, mem_en}, 32'd1);
    tick; req_valid = 0;
    @(negedge clk); chk("t1_n1_valid", {31'b0, rsp_valid}, 32'd0);
    tick;
    @(negedge clk);
    chk("t1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t1_inst", rsp_inst, 32'h00500093);
    chk("t1_pc", rsp_pc, 32'h10);
    rsp_ready = 1;
    tick;

    // Back-to-back fetches, one response per cycle
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 4); req_pc = 32'(4 * k);
      @(negedge clk);
      if (k < 4) chk("t2_ready", {31'b0, req_ready}, 32'd1);
      if (k >= 2) begin
        chk("t2_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t2_pc", rsp_pc, 32'(4 * (k - 2)));
      end
      tick;
    end
    req_valid = 0; tick; tick;

    // Backpressure: exactly DEPTH accepted
    rsp_ready = 0; nacc = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1; req_pc = 32'h40 + 32'(4 * nacc);
      @(negedge clk);
      if (req_ready) nacc++;
      tick;
    end
    @(negedge clk);
    chk("t3_nacc", 32'(nacc), 32'd4);
    chk("t3_ready", {31'b0, req_ready}, 32'd0);
    req_valid = 0; rsp_ready = 1;
    for (int k = 0; k < 6; k++) tick;
    @(negedge clk);
    chk("t3_drained", {31'b0, rsp_valid}, 32'd0);
    chk("t3_ready_back", {31'b0, req_ready}, 32'd1);

    // Flush with two buffered and 0x20 in flight
    rsp_ready = 0;
    req_valid = 1; req_pc = 32'h80; tick;
    req_pc = 32'h84; tick;
    req_pc = 32'h20; tick;
    req_valid = 0; flush = 1;
    @(negedge clk);
    chk("t4_flush_ready", {31'b0, req_ready}, 32'd0);
    chk("t4_pre_valid", {31'b0, rsp_valid}, 32'd1);
    tick;
    flush = 0; req_valid = 1; req_pc = 32'h100; rsp_ready = 1;
    @(negedge clk);
    chk("t4_post_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t4_post_ready", {31'b0, req_ready}, 32'd1);
    tick; req_valid = 0;
    @(negedge clk); chk("t4_n1_valid", {31'b0, rsp_valid}, 32'd0);
    tick;
    @(negedge clk);
    chk("t4_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t4_pc", rsp_pc, 32'h100);
    tick; tick;

    // Misaligned fetch between two aligned ones
    for (int k = 0; k < 5; k++) begin
      req_valid = (k < 3);
      req_pc = (k == 0) ? 32'h0 : (k == 1) ? 32'h6 : 32'h4;
      @(negedge clk);
      if (k == 1) begin
        if (MIS_EN) chk("t5_mis_en", {31'b0, mem_en}, 32'd0);
        else begin
          chk("t5_mem_en", {31'b0, mem_en}, 32'd1);
          chk("t5_mem_a", {18'b0, mem_a}, 32'd1);
        end
      end
      if (k == 2) chk("t5_pc0", rsp_pc, 32'h0);
      if (k == 3) begin
        chk("t5_pc6", rsp_pc, 32'h6);
        chk("t5_err", {31'b0, rsp_err}, {31'b0, MIS_EN});
        chk("t5_inst", rsp_inst, MIS_EN ? 32'h00000013 : ram[1]);
      end
      if (k == 4) chk("t5_pc4", rsp_pc, 32'h4);
      tick;
    end
    req_valid = 0; tick; tick;

    // Reset with three buffered and one in flight
    rsp_ready = 0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1; req_pc = 32'h200 + 32'(4 * k); tick;
    end
    rst = 0; req_pc = 32'h300;
    @(negedge clk);
    chk("t6_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("t6_rst_mem_en", {31'b0, mem_en}, 32'd0);
    tick;
    rst = 1; req_valid = 0;
    @(negedge clk);
    chk("t6_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t6_pc", rsp_pc, 32'h0);
    chk("t6_inst", rsp_inst, 32'h0);
    chk("t6_err", {31'b0, rsp_err}, 32'h0);
    for (int k = 0; k < 3; k++) tick;
    @(negedge clk);
    chk("t6_no_stale", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1; req_valid = 1; req_pc = 32'h10; tick;
    req_valid = 0;
    for (int k = 0; k < 4; k++) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
